// File: rtl/nn_load_scheduler_if.sv
// Stream and SRAM write-port bundle between the job scheduler and its neighbours:
// pixel and weight-2 valid/ready streams in, registered SRAM write strobes/data out.
interface nn_load_scheduler_if #(
    parameter int PIX_W = 90,
    parameter int W2_DW = 16,
    parameter int W2_AW = 4
);
    logic             pix_valid;
    logic             pix_ready;
    logic [PIX_W-1:0] pix_data;

    logic             w2_valid;
    logic             w2_ready;
    logic [W2_DW-1:0] w2_data;

    logic             inputSramWe;
    logic [PIX_W-1:0] pixels;
    logic             w2SramWeOffChip;
    logic [W2_DW-1:0] weight2;
    logic [W2_AW-1:0] weight2AddrOffChip;

    modport master (
        output pix_valid, pix_data, w2_valid, w2_data,
        input  pix_ready, w2_ready,
        input  inputSramWe, pixels, w2SramWeOffChip, weight2, weight2AddrOffChip
    );

    modport slave (
        input  pix_valid, pix_data, w2_valid, w2_data,
        output pix_ready, w2_ready,
        output inputSramWe, pixels, w2SramWeOffChip, weight2, weight2AddrOffChip
    );
endinterface

// File: rtl/nn_load_scheduler.sv
// Job sequencer: loads one pixel word and (unless reused) a full weight-2 set, then
// releases the layer controller and waits for compute_done under a watchdog.
module nn_load_scheduler #(
    parameter int W2_DEPTH    = 16,
    parameter int W2_AW       = 4,
    parameter int W2_DW       = 16,
    parameter int PIX_W       = 90,
    parameter int RUN_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               reuse_w2,
    input  logic               abort,
    input  logic               compute_done,
    nn_load_scheduler_if.slave bus,
    output logic               core_reset,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam int WD_W = $clog2(RUN_TIMEOUT + 1);
    localparam logic [W2_AW-1:0] ADDR_LAST = W2_AW'(W2_DEPTH - 1);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(RUN_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LOAD_PIX, LOAD_W2, SETTLE, RUN} state_t;

    state_t             state_q, state_d;
    logic               reuse_q, reuse_d;
    logic               w2_loaded_q, w2_loaded_d;
    logic [W2_AW-1:0]   addr_q, addr_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic               pix_we_q, pix_we_d;
    logic [PIX_W-1:0]   pixels_q, pixels_d;
    logic               w2_we_q, w2_we_d;
    logic [W2_DW-1:0]   weight2_q, weight2_d;
    logic [W2_AW-1:0]   w2_addr_q, w2_addr_d;
    logic               core_reset_q, core_reset_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic pix_fire;
    logic w2_fire;

    assign bus.pix_ready = (state_q == LOAD_PIX);
    assign bus.w2_ready  = (state_q == LOAD_W2);
    assign pix_fire      = bus.pix_valid && (state_q == LOAD_PIX);
    assign w2_fire       = bus.w2_valid && (state_q == LOAD_W2);

    always_comb begin
        state_d     = state_q;
        reuse_d     = reuse_q;
        w2_loaded_d = w2_loaded_q;
        addr_d      = addr_q;
        wdog_d      = wdog_q;
        pix_we_d    = 1'b0;
        pixels_d    = pixels_q;
        w2_we_d     = 1'b0;
        weight2_d   = weight2_q;
        w2_addr_d   = w2_addr_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                wdog_d = '0;
                if (start && !abort) begin
                    state_d = LOAD_PIX;
                    reuse_d = reuse_w2;
                end
            end
            LOAD_PIX: begin
                if (pix_fire) begin
                    pix_we_d = 1'b1;
                    pixels_d = bus.pix_data;
                    addr_d   = '0;
                    state_d  = (reuse_q && w2_loaded_q) ? SETTLE : LOAD_W2;
                end
            end
            LOAD_W2: begin
                if (w2_fire) begin
                    w2_we_d   = 1'b1;
                    weight2_d = bus.w2_data;
                    w2_addr_d = addr_q;
                    if (addr_q == ADDR_LAST) begin
                        addr_d      = '0;
                        w2_loaded_d = 1'b1;
                        state_d     = SETTLE;
                    end else begin
                        addr_d = addr_q + W2_AW'(1);
                    end
                end
            end
            SETTLE: begin
                wdog_d  = '0;
                state_d = RUN;
            end
            RUN: begin
                // compute_done is checked first so it wins a tie with expiry
                if (compute_done) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (wdog_q == WD_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort kills any write still in flight so nothing lands after it
        if (abort && (state_q != IDLE)) begin
            state_d  = IDLE;
            pix_we_d = 1'b0;
            w2_we_d  = 1'b0;
            done_d   = 1'b0;
            err_d    = 1'b0;
            addr_d   = '0;
            wdog_d   = '0;
            if (state_q == LOAD_W2) begin
                w2_loaded_d = 1'b0;
            end
        end

        core_reset_d = (state_d != RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            reuse_q      <= 1'b0;
            w2_loaded_q  <= 1'b0;
            addr_q       <= '0;
            wdog_q       <= '0;
            pix_we_q     <= 1'b0;
            pixels_q     <= '0;
            w2_we_q      <= 1'b0;
            weight2_q    <= '0;
            w2_addr_q    <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            reuse_q      <= reuse_d;
            w2_loaded_q  <= w2_loaded_d;
            addr_q       <= addr_d;
            wdog_q       <= wdog_d;
            pix_we_q     <= pix_we_d;
            pixels_q     <= pixels_d;
            w2_we_q      <= w2_we_d;
            weight2_q    <= weight2_d;
            w2_addr_q    <= w2_addr_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.inputSramWe        = pix_we_q;
    assign bus.pixels             = pixels_q;
    assign bus.w2SramWeOffChip    = w2_we_q;
    assign bus.weight2            = weight2_q;
    assign bus.weight2AddrOffChip = w2_addr_q;
    assign core_reset             = core_reset_q;
    assign busy                   = (state_q != IDLE);
    assign done                   = done_q;
    assign err                    = err_q;
endmodule

// File: tb/tb_nn_load_scheduler.sv
// Self-checking bench for nn_load_scheduler: a table of whole jobs plus hand-written
// reset/ignore sequences, with a write scoreboard fed from accepted stream beats.
`timescale 1ns/1ps
module tb_nn_load_scheduler;
    localparam int PIX_W       = 90;
    localparam int W2_DW       = 16;
    localparam int W2_AW       = 4;
    localparam int W2_DEPTH    = 16;
    localparam int RUN_TIMEOUT = 1024;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic reuse_w2 = 1'b0;
    logic abort = 1'b0;
    logic compute_done = 1'b0;
    logic core_reset, busy, done, err;

    nn_load_scheduler_if #(.PIX_W(PIX_W), .W2_DW(W2_DW), .W2_AW(W2_AW)) bus ();

    nn_load_scheduler #(
        .W2_DEPTH(W2_DEPTH), .W2_AW(W2_AW), .W2_DW(W2_DW),
        .PIX_W(PIX_W), .RUN_TIMEOUT(RUN_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .reuse_w2(reuse_w2),
        .abort(abort), .compute_done(compute_done), .bus(bus),
        .core_reset(core_reset), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                 is_w2;
        int                 cyc;
        logic [PIX_W-1:0]   data;
        logic [W2_AW-1:0]   addr;
    } wr_t;

    typedef struct {
        bit reuse;
        bit toggle;
        int abort_after;
        int done_after;
        int exp_pix;
        int exp_w2;
        int exp_done;
        int exp_err;
        int exp_run;
        int exp_gap;
    } job_t;

    int   n_checks = 0;
    int   n_fail = 0;
    wr_t  sbq[$];
    int   cyc_cnt = 0, pix_wr_cnt = 0, w2_wr_cnt = 0, run_cnt = 0;
    int   done_cnt = 0, err_cnt = 0, pix_we_cyc = -1, run_start_cyc = -1, w2_idx = 0;
    logic prev_core_reset = 1'b1;
    logic [W2_DW-1:0] wtab [W2_DEPTH];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Negedge monitor: retire observed writes against the scoreboard, then log new beats.
    task automatic sample();
        wr_t e;
        cyc_cnt++;
        if (!reset) begin
            sbq.delete();
            w2_idx = 0;
            prev_core_reset = 1'b1;
            return;
        end
        if (bus.inputSramWe) begin
            pix_wr_cnt++;
            pix_we_cyc = cyc_cnt;
            check("pix_sb_pending", (sbq.size() > 0), 1'b1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("pix_kind", e.is_w2, 1'b0);
                check("pix_latency", cyc_cnt - e.cyc, 1);
                check("pix_data", bus.pixels, e.data);
            end
        end
        if (bus.w2SramWeOffChip) begin
            w2_wr_cnt++;
            check("w2_sb_pending", (sbq.size() > 0), 1'b1);
            check("w2_we_outside_run", core_reset, 1'b1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("w2_kind", e.is_w2, 1'b1);
                check("w2_latency", cyc_cnt - e.cyc, 1);
                check("w2_data", bus.weight2, e.data[W2_DW-1:0]);
                check("w2_addr", bus.weight2AddrOffChip, e.addr);
            end
        end
        if (!core_reset) begin
            run_cnt++;
            if (prev_core_reset) run_start_cyc = cyc_cnt;
        end
        prev_core_reset = core_reset;
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (bus.pix_valid && bus.pix_ready) begin
            e.is_w2 = 1'b0; e.cyc = cyc_cnt; e.data = bus.pix_data; e.addr = '0;
            sbq.push_back(e);
            w2_idx = 0;
        end
        if (bus.w2_valid && bus.w2_ready) begin
            e.is_w2 = 1'b1; e.cyc = cyc_cnt;
            e.data = {{(PIX_W-W2_DW){1'b0}}, bus.w2_data};
            e.addr = W2_AW'(w2_idx);
            sbq.push_back(e);
            w2_idx = (w2_idx + 1) % W2_DEPTH;
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
        sample();
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_inputSramWe"}, bus.inputSramWe, 1'b0);
        check({tag, "_pixels"}, bus.pixels, '0);
        check({tag, "_w2SramWe"}, bus.w2SramWeOffChip, 1'b0);
        check({tag, "_weight2"}, bus.weight2, '0);
        check({tag, "_w2addr"}, bus.weight2AddrOffChip, '0);
        check({tag, "_core_reset"}, core_reset, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_pix_ready"}, bus.pix_ready, 1'b0);
        check({tag, "_w2_ready"}, bus.w2_ready, 1'b0);
    endtask

    task automatic run_job(input int idx, input job_t j);
        int pb = pix_wr_cnt, wb = w2_wr_cnt, rb = run_cnt, db = done_cnt, eb = err_cnt;
        int beats = 0, cyc = 0, abort_cyc = -1, exit_cyc = -1;
        bit pix_done = 0, aborted = 0, fin = 0;
        logic exit_done = 1'b0, exit_err = 1'b0;
        logic [95:0] r;
        start = 1'b1; reuse_w2 = j.reuse;
        to_neg(); to_pos();
        start = 1'b0; reuse_w2 = 1'b0;
        while (!fin && cyc < 3000) begin
            r = {$urandom(), $urandom(), $urandom()};
            bus.pix_valid = !pix_done;
            bus.pix_data  = r[PIX_W-1:0];
            bus.w2_data   = wtab[beats % W2_DEPTH];
            bus.w2_valid  = pix_done && (beats < W2_DEPTH) && (!j.toggle || cyc[0]);
            abort = 1'b0;
            if (j.abort_after >= 0 && beats >= j.abort_after && !aborted) begin
                abort = 1'b1; bus.w2_valid = 1'b0; aborted = 1; abort_cyc = cyc;
            end
            compute_done = !core_reset && (run_cnt - rb + 1 == j.done_after);
            to_neg();
            if (bus.pix_valid && bus.pix_ready) pix_done = 1;
            if (bus.w2_valid && bus.w2_ready) beats++;
            if (!busy) begin
                fin = 1; exit_cyc = cyc; exit_done = done; exit_err = err;
            end
            cyc++;
            to_pos();
        end
        bus.pix_valid = 1'b0; bus.w2_valid = 1'b0; abort = 1'b0; compute_done = 1'b0;
        to_neg();
        check($sformatf("job%0d_finished", idx), fin, 1'b1);
        check($sformatf("job%0d_done_pulse_width", idx), done, 1'b0);
        check($sformatf("job%0d_err_pulse_width", idx), err, 1'b0);
        check($sformatf("job%0d_pix_writes", idx), pix_wr_cnt - pb, j.exp_pix);
        check($sformatf("job%0d_w2_writes", idx), w2_wr_cnt - wb, j.exp_w2);
        check($sformatf("job%0d_run_cycles", idx), run_cnt - rb, j.exp_run);
        check($sformatf("job%0d_done_count", idx), done_cnt - db, j.exp_done);
        check($sformatf("job%0d_err_count", idx), err_cnt - eb, j.exp_err);
        check($sformatf("job%0d_exit_done", idx), exit_done, j.exp_done[0]);
        check($sformatf("job%0d_exit_err", idx), exit_err, j.exp_err[0]);
        check($sformatf("job%0d_sb_empty", idx), sbq.size(), 0);
        if (aborted) check($sformatf("job%0d_idle_after_abort", idx), exit_cyc, abort_cyc + 1);
        if (j.exp_gap >= 0) check($sformatf("job%0d_pixwr_to_run", idx), run_start_cyc - pix_we_cyc, j.exp_gap);
        $display("job %0d: reuse=%0d toggle=%0d pix_wr=%0d w2_wr=%0d run=%0d done=%0d err=%0d",
                 idx, j.reuse, j.toggle, pix_wr_cnt - pb, w2_wr_cnt - wb, run_cnt - rb,
                 done_cnt - db, err_cnt - eb);
        to_pos();
    endtask

    job_t jobs [7];

    initial begin
        logic [95:0] r;
        int seen_pix_ready;
        for (int i = 0; i < W2_DEPTH - 1; i++) wtab[i] = W2_DW'((i + 1) << 8);
        wtab[W2_DEPTH-1] = 16'hFF00;
        //          reuse tog abort done  pix w2 dn er run   gap
        jobs[0] = '{1'b1, 1'b0, -1,   40,  1, 16, 1, 0,   40, 17};
        jobs[1] = '{1'b1, 1'b0, -1,    5,  1,  0, 1, 0,    5,  1};
        jobs[2] = '{1'b0, 1'b1,  7,    0,  1,  7, 0, 0,    0, -1};
        jobs[3] = '{1'b1, 1'b1, -1,    3,  1, 16, 1, 0,    3, -1};
        jobs[4] = '{1'b1, 1'b0, -1,    0,  1,  0, 0, 1, 1024,  1};
        jobs[5] = '{1'b1, 1'b0, -1, 1024,  1,  0, 1, 0, 1024,  1};
        jobs[6] = '{1'b0, 1'b0, -1,    1,  1, 16, 1, 0,    1, 17};

        bus.pix_valid = 1'b0; bus.pix_data = '0; bus.w2_valid = 1'b0; bus.w2_data = '0;
        to_neg(); to_neg();
        check_reset_outputs("por");
        $display("power-on reset outputs checked");
        to_pos();
        reset = 1'b1;
        to_pos();

        // Reset in the middle of a weight load, after five accepted beats
        start = 1'b1; reuse_w2 = 1'b0;
        to_neg(); to_pos();
        start = 1'b0;
        r = {$urandom(), $urandom(), $urandom()};
        bus.pix_valid = 1'b1; bus.pix_data = r[PIX_W-1:0];
        to_neg(); to_pos();
        bus.pix_valid = 1'b0;
        bus.w2_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.w2_data = wtab[k];
            to_neg(); to_pos();
        end
        bus.w2_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_load_reset");
        $display("reset during LOAD_W2 after 5 beats: outputs checked");
        to_neg(); to_pos();
        reset = 1'b1;
        to_pos();

        for (int i = 0; i < 7; i++) run_job(i, jobs[i]);

        // compute_done in LOAD_PIX and start in RUN must both be ignored
        start = 1'b1; reuse_w2 = 1'b1;
        to_neg(); to_pos();
        start = 1'b0; reuse_w2 = 1'b0; compute_done = 1'b1;
        to_neg();
        check("ign_cd_busy", busy, 1'b1);
        check("ign_cd_pix_ready", bus.pix_ready, 1'b1);
        check("ign_cd_core_reset", core_reset, 1'b1);
        to_pos();
        compute_done = 1'b0;
        to_neg();
        check("ign_cd_still_load_pix", bus.pix_ready, 1'b1);
        check("ign_cd_no_done", done, 1'b0);
        check("ign_cd_no_err", err, 1'b0);
        to_pos();
        r = {$urandom(), $urandom(), $urandom()};
        bus.pix_valid = 1'b1; bus.pix_data = r[PIX_W-1:0];
        to_neg(); to_pos();
        bus.pix_valid = 1'b0;
        to_neg();
        check("ign_settle_core_reset", core_reset, 1'b1);
        check("ign_settle_pix_we", bus.inputSramWe, 1'b1);
        to_pos();
        start = 1'b1;
        to_neg();
        check("ign_start_run_core_reset", core_reset, 1'b0);
        to_pos();
        start = 1'b0;
        to_neg();
        seen_pix_ready = bus.pix_ready ? 1 : 0;
        check("ign_start_busy", busy, 1'b1);
        check("ign_start_core_reset", core_reset, 1'b0);
        check("ign_start_pix_ready", seen_pix_ready, 0);
        to_pos();
        compute_done = 1'b1;
        to_neg(); to_pos();
        compute_done = 1'b0;
        to_neg();
        check("ign_final_done", done, 1'b1);
        check("ign_final_busy", busy, 1'b0);
        check("ign_final_core_reset", core_reset, 1'b1);
        to_pos();
        to_neg();
        check("ign_final_done_low", done, 1'b0);
        check("ign_final_sb_empty", sbq.size(), 0);
        $display("start in RUN / compute_done in LOAD_PIX sequence checked");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "global timeout");
    end
endmodule
